// File: rtl/vga_sync.sv
// vga_sync: 640x480 raster timing generator; pixel-tick divider, scan counters,
// active-low syncs registered from the next counter values so they line up with pixel_x/pixel_y.
module vga_sync #(
   parameter int HD = 640,
   parameter int HF = 16,
   parameter int HR = 96,
   parameter int HB = 48,
   parameter int VD = 480,
   parameter int VF = 10,
   parameter int VR = 2,
   parameter int VB = 33,
   parameter int TICK_DIV = 2
) (
   input  logic       clk,
   input  logic       reset,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start
);
   localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
   localparam logic [9:0] HMAX = 10'(HD + HF + HR + HB - 1);
   localparam logic [9:0] VMAX = 10'(VD + VF + VR + VB - 1);
   localparam logic [9:0] HDISP = 10'(HD);
   localparam logic [9:0] VDISP = 10'(VD);
   localparam logic [9:0] HS_LO = 10'(HD + HF);
   localparam logic [9:0] HS_HI = 10'(HD + HF + HR - 1);
   localparam logic [9:0] VS_LO = 10'(VD + VF);
   localparam logic [9:0] VS_HI = 10'(VD + VF + VR - 1);
   logic [TW-1:0] tick, tick_n;
   logic [9:0]    h, v, h_n, v_n;
   logic          h_end, v_end;
   always_comb begin
      p_tick = tick == TMAX;
      h_end = h == HMAX;
      v_end = v == VMAX;
      tick_n = p_tick ? '0 : tick + 1'b1;
      h_n = p_tick ? (h_end ? '0 : h + 10'd1) : h;
      v_n = (p_tick && h_end) ? (v_end ? '0 : v + 10'd1) : v;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         tick <= '0;
         h <= '0;
         v <= '0;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         tick <= tick_n;
         h <= h_n;
         v <= v_n;
         hsync <= !(h_n >= HS_LO && h_n <= HS_HI);
         vsync <= !(v_n >= VS_LO && v_n <= VS_HI);
      end
   end
   assign pixel_x = h;
   assign pixel_y = v;
   assign video_on = h < HDISP && v < VDISP;
   assign frame_start = p_tick && h_end && v_end;
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: three instances (default, shrunken raster, TICK_DIV=1) checked every clk
// against a cycle-count raster model through a scoreboard queue, plus sync/line/frame length checks.
module tb_vga_sync;
   logic clk;
   logic rst [3];
   logic pt [3];
   logic [9:0] px [3];
   logic [9:0] py [3];
   logic vo [3], hs [3], vs [3], fs [3];
   logic [24:0] obs [3];
   logic [24:0] q [3][$];
   int c [3];
   int errs = 0;
   int checks = 0;

   vga_sync u0 (
      .clk(clk), .reset(rst[0]), .p_tick(pt[0]), .pixel_x(px[0]), .pixel_y(py[0]),
      .video_on(vo[0]), .hsync(hs[0]), .vsync(vs[0]), .frame_start(fs[0])
   );
   vga_sync #(.HD(8), .HF(2), .HR(3), .HB(2), .VD(6), .VF(2), .VR(2), .VB(3), .TICK_DIV(2)) u1 (
      .clk(clk), .reset(rst[1]), .p_tick(pt[1]), .pixel_x(px[1]), .pixel_y(py[1]),
      .video_on(vo[1]), .hsync(hs[1]), .vsync(vs[1]), .frame_start(fs[1])
   );
   vga_sync #(.TICK_DIV(1)) u2 (
      .clk(clk), .reset(rst[2]), .p_tick(pt[2]), .pixel_x(px[2]), .pixel_y(py[2]),
      .video_on(vo[2]), .hsync(hs[2]), .vsync(vs[2]), .frame_start(fs[2])
   );

   for (genvar g = 0; g < 3; g++) begin : g_obs
      assign obs[g] = {pt[g], px[g], py[g], vo[g], hs[g], vs[g], fs[g]};
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // expected outputs after c clk edges since reset: pixel count is c/TICK_DIV
   function automatic logic [24:0] model(input int k, input int cyc);
      int hd, hf, hr, hb, vd, vf, vr, vb, td, ht, vt, p, h, v;
      logic ptk;
      hd = 640; hf = 16; hr = 96; hb = 48; vd = 480; vf = 10; vr = 2; vb = 33; td = 2;
      if (k == 1) begin
         hd = 8; hf = 2; hr = 3; hb = 2; vd = 6; vf = 2; vr = 2; vb = 3;
      end
      if (k == 2) td = 1;
      ht = hd + hf + hr + hb;
      vt = vd + vf + vr + vb;
      p = cyc / td;
      h = p % ht;
      v = (p / ht) % vt;
      ptk = (cyc % td) == td - 1;
      return {ptk, 10'(h), 10'(v), (h < hd) && (v < vd),
              !((h >= hd + hf) && (h < hd + hf + hr)),
              !((v >= vd + vf) && (v < vd + vf + vr)),
              ptk && (h == ht - 1) && (v == vt - 1)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errs++;
         $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
      end
   endtask

   task automatic tick();
      for (int k = 0; k < 3; k++) begin
         c[k] = rst[k] ? 0 : c[k] + 1;
         q[k].push_back(model(k, c[k]));
      end
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++)
         chk($sformatf("dut%0d cyc=%0d {pt,x,y,von,hs,vs,fs}", k, c[k]), 32'(obs[k]), 32'(q[k].pop_front()));
   endtask

   // per=0: clks spent at val from now; per=1: clks between successive entries into val
   task automatic meas(input int k, input int b, input logic val, input bit per, output int n);
      int i;
      i = 0;
      n = 0;
      while (obs[k][b] === val && i < 4000) begin tick(); i++; end
      while (obs[k][b] !== val && i < 4000) begin tick(); i++; end
      if (!per) begin
         while (obs[k][b] === val && i < 4000) begin tick(); n++; i++; end
      end else begin
         while (obs[k][b] === val && i < 4000) begin tick(); n++; i++; end
         while (obs[k][b] !== val && i < 4000) begin tick(); n++; i++; end
      end
      if (i >= 4000) n = -1;
   endtask

   initial begin
      int n;
      bit found;
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1;
         c[k] = 0;
      end
      repeat (3) tick();
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
      repeat (200) tick();
      found = 0;
      for (int i = 0; i < 500 && !found; i++) begin
         tick();
         if (obs[1][2:1] == 2'b00) found = 1;
      end
      chk("dut1 reached hsync&vsync low", 32'(found), 32'd1);
      rst[1] = 1'b1;
      tick();
      chk("dut1 mid-frame reset x,y,hs,vs,fs", {8'd0, px[1], py[1], hs[1], vs[1], fs[1], 1'b0},
          {8'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0});
      rst[1] = 1'b0;
      repeat (3400) tick();
      meas(0, 2, 1'b0, 1'b1, n);
      chk("dut0 line clks", 32'(n), 32'd1600);
      meas(0, 2, 1'b0, 1'b0, n);
      chk("dut0 hsync low clks", 32'(n), 32'd192);
      meas(1, 0, 1'b1, 1'b1, n);
      chk("dut1 frame_start spacing", 32'(n), 32'd390);
      meas(1, 0, 1'b1, 1'b0, n);
      chk("dut1 frame_start width", 32'(n), 32'd1);
      meas(1, 1, 1'b0, 1'b0, n);
      chk("dut1 vsync low clks", 32'(n), 32'd60);
      meas(2, 2, 1'b0, 1'b1, n);
      chk("dut2 line clks", 32'(n), 32'd800);
      meas(2, 2, 1'b0, 1'b0, n);
      chk("dut2 hsync low clks", 32'(n), 32'd96);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
